// File: rtl/game_pkg.sv
// Shared types and constants for the game controller score logic.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HOLD = 2'd1,
        OVER = 2'd2
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/score_keeper_bcd_counter.sv
// Per-player BCD score counter with a ripple carry chain, saturation at
// all-9s and a binary shadow copy used for the win comparison.
module bcd_counter
    import game_pkg::*;
#(
    parameter int DIGITS = 2,
    localparam int SHADOW_W = $clog2(10 ** DIGITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  inc,
    output logic [DIGITS*4-1:0]   bcd,
    output logic [SHADOW_W-1:0]   shadow_next
);

    bcd_digit_t [DIGITS-1:0] digits_q, digits_d;
    logic [SHADOW_W-1:0]     shadow_q, shadow_d;
    logic                    all_nines;
    logic                    carry;

    // Saturation detect: every digit already at its maximum value.
    always_comb begin
        all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (digits_q[i] != BCD_MAX_DIGIT) begin
                all_nines = 1'b0;
            end
        end
    end

    // Next-value logic: clear wins over increment, increment ripples a carry
    // digit by digit and the shadow follows the same saturating rule.
    always_comb begin
        digits_d    = digits_q;
        shadow_d    = shadow_q;
        carry       = 1'b1;
        shadow_next = all_nines ? shadow_q : shadow_q + 1'b1;
        if (clr) begin
            digits_d = '0;
            shadow_d = '0;
        end else if (inc && !all_nines) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (digits_q[i] == BCD_MAX_DIGIT) begin
                        digits_d[i] = 4'd0;
                    end else begin
                        digits_d[i] = digits_q[i] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
            shadow_d = shadow_q + 1'b1;
        end
    end

    // Score registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_q <= '0;
            shadow_q <= '0;
        end else begin
            digits_q <= digits_d;
            shadow_q <= shadow_d;
        end
    end

    assign bcd = digits_q;

endmodule

// File: rtl/score_keeper.sv
// Multi-player BCD score keeper: credits one point per rising score request
// (lowest index wins ties), enforces a lockout after each point and freezes
// all scores once a player reaches the winning score.
module score_keeper
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int DIGITS      = 2,
    parameter int WIN_SCORE   = 11,
    parameter int HOLD_CYCLES = 1024,
    localparam int WINNER_W   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int SCORE_W    = DIGITS * 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic [NUM_PLAYERS-1:0]         score_event,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score_bcd,
    output logic [NUM_PLAYERS-1:0]         point_pulse,
    output logic                           game_over,
    output logic [WINNER_W-1:0]            winner,
    output logic                           busy
);

    localparam int SHADOW_W = $clog2(10 ** DIGITS);
    localparam int CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [SHADOW_W-1:0] WIN_VAL   = SHADOW_W'(WIN_SCORE);

    if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8) begin : g_bad_players
        $error("score_keeper: NUM_PLAYERS must be 1..8");
    end
    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
        $error("score_keeper: DIGITS must be 1..4");
    end
    if (WIN_SCORE < 0 || WIN_SCORE > (10 ** DIGITS) - 1) begin : g_bad_win
        $error("score_keeper: WIN_SCORE must be 0..10**DIGITS-1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("score_keeper: HOLD_CYCLES must be at least 1");
    end

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_PLAYERS-1:0] ev_q;
    logic [NUM_PLAYERS-1:0] pulse_q, pulse_d;
    logic [WINNER_W-1:0]    winner_q, winner_d;

    logic [NUM_PLAYERS-1:0] rise;
    logic [NUM_PLAYERS-1:0] sel_onehot;
    logic [NUM_PLAYERS-1:0] inc_vec;
    logic [WINNER_W-1:0]    sel_idx;
    logic                   sel_valid;
    logic                   win_hit;
    logic [SHADOW_W-1:0]    shadow_next [NUM_PLAYERS];

    assign rise = score_event & ~ev_q;

    // Pick the lowest-index rising player and check whether its next score wins.
    always_comb begin
        sel_valid  = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        win_hit    = 1'b0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (rise[i]) begin
                sel_valid     = 1'b1;
                sel_idx       = WINNER_W'(i);
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                win_hit       = (WIN_SCORE != 0) && (shadow_next[i] == WIN_VAL);
            end
        end
    end

    // Game state machine: crediting, lockout countdown and game-over freeze.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pulse_d  = '0;
        winner_d = winner_q;
        inc_vec  = '0;
        if (clear) begin
            state_d  = PLAY;
            cnt_d    = '0;
            winner_d = '0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (sel_valid) begin
                        inc_vec = sel_onehot;
                        pulse_d = sel_onehot;
                        if (win_hit) begin
                            state_d  = OVER;
                            winner_d = sel_idx;
                        end else begin
                            state_d = HOLD;
                            cnt_d   = HOLD_LOAD;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = PLAY;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                OVER: begin
                    state_d = OVER;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end
    end

    // State, lockout counter, edge history, strobe and winner registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= PLAY;
            cnt_q    <= '0;
            ev_q     <= '0;
            pulse_q  <= '0;
            winner_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ev_q     <= score_event;
            pulse_q  <= pulse_d;
            winner_q <= winner_d;
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
        bcd_counter #(
            .DIGITS(DIGITS)
        ) u_counter (
            .clk        (clk),
            .reset      (reset),
            .clr        (clear),
            .inc        (inc_vec[g]),
            .bcd        (score_bcd[g*SCORE_W +: SCORE_W]),
            .shadow_next(shadow_next[g])
        );
    end

    assign point_pulse = pulse_q;
    assign game_over   = (state_q == OVER);
    assign busy        = (state_q == HOLD);
    assign winner      = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: two instances (a win-limited two-digit
// game and a free-running single-digit game) share the same stimulus and are
// compared against a per-player integer score model.
module tb_score_keeper;

    localparam int A_DIGITS = 2;
    localparam int A_WIN    = 11;
    localparam int A_HOLD   = 4;
    localparam int B_DIGITS = 1;
    localparam int B_WIN    = 0;
    localparam int B_HOLD   = 1;

    typedef struct {
        logic [1:0]  pulse;
        logic [15:0] bcd;
        logic        over;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [1:0]  score_event;

    logic [15:0] bcd_a;
    logic [1:0]  pulse_a;
    logic        over_a;
    logic        winner_a;
    logic        busy_a;
    logic [7:0]  bcd_b;
    logic [1:0]  pulse_b;
    logic        over_b;
    logic        winner_b;
    logic        busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    int   m_score  [2][2];
    int   m_hold   [2];
    bit   m_over   [2];
    int   m_winner [2];
    int   pushed   [2];
    int   seen     [2];
    logic [1:0] m_prev;
    logic [1:0] m_rise;
    exp_t q_a[$];
    exp_t q_b[$];

    score_keeper #(
        .NUM_PLAYERS(2), .DIGITS(A_DIGITS), .WIN_SCORE(A_WIN), .HOLD_CYCLES(A_HOLD)
    ) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .score_event(score_event),
        .score_bcd(bcd_a), .point_pulse(pulse_a), .game_over(over_a),
        .winner(winner_a), .busy(busy_a)
    );

    score_keeper #(
        .NUM_PLAYERS(2), .DIGITS(B_DIGITS), .WIN_SCORE(B_WIN), .HOLD_CYCLES(B_HOLD)
    ) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .score_event(score_event),
        .score_bcd(bcd_b), .point_pulse(pulse_b), .game_over(over_b),
        .winner(winner_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    function automatic int digitsOf(int k);
        return (k == 0) ? A_DIGITS : B_DIGITS;
    endfunction

    function automatic logic [15:0] toBcd(int k);
        logic [15:0] r;
        int v;
        int dg;
        r  = '0;
        dg = digitsOf(k);
        for (int p = 0; p < 2; p++) begin
            v = m_score[k][p];
            for (int d = 0; d < dg; d++) begin
                r[(p*dg + d)*4 +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for one game: plain integer scores and a lockout count.
    task automatic modelEdge(input int k, input logic [1:0] rise);
        int   win;
        int   hold;
        int   maxs;
        int   p;
        exp_t e;
        win  = (k == 0) ? A_WIN : B_WIN;
        hold = (k == 0) ? A_HOLD : B_HOLD;
        maxs = (10 ** digitsOf(k)) - 1;
        if (clear) begin
            m_score[k][0] = 0;
            m_score[k][1] = 0;
            m_hold[k]     = 0;
            m_over[k]     = 1'b0;
            m_winner[k]   = 0;
        end else if (m_over[k]) begin
            m_hold[k] = 0;
        end else if (m_hold[k] > 0) begin
            m_hold[k]--;
        end else if (rise != 2'b00) begin
            p = rise[0] ? 0 : 1;
            if (m_score[k][p] < maxs) m_score[k][p]++;
            if (win != 0 && m_score[k][p] == win) begin
                m_over[k]   = 1'b1;
                m_winner[k] = p;
            end else begin
                m_hold[k] = hold;
            end
            e.pulse = (p == 0) ? 2'b01 : 2'b10;
            e.bcd   = toBcd(k);
            e.over  = m_over[k];
            pushed[k]++;
            if (k == 0) q_a.push_back(e);
            else        q_b.push_back(e);
        end
    endtask

    // Model advances on the same edges as the DUTs and pushes expected credits.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_prev = 2'b00;
            for (int k = 0; k < 2; k++) begin
                m_score[k][0] = 0;
                m_score[k][1] = 0;
                m_hold[k]     = 0;
                m_over[k]     = 1'b0;
                m_winner[k]   = 0;
            end
        end else begin
            m_rise = score_event & ~m_prev;
            m_prev = score_event;
            modelEdge(0, m_rise);
            modelEdge(1, m_rise);
        end
    end

    // Compare one instance: pops a pending credit when a strobe is seen (or
    // was expected) and checks the steady outputs against the model.
    task automatic checkOutput(input int k, input logic [1:0] pulse, input logic [15:0] bcd,
                               input logic over, input logic win, input logic busy);
        exp_t e;
        int   qs;
        string tag;
        tag = (k == 0) ? "a" : "b";
        qs  = (k == 0) ? q_a.size() : q_b.size();
        if (pulse !== 2'b00) seen[k]++;
        if (pulse !== 2'b00 || qs > 0) begin
            if (qs == 0) begin
                cmp({tag, "_unexpected_pulse"}, 32'(pulse), 32'd0);
            end else begin
                e = (k == 0) ? q_a.pop_front() : q_b.pop_front();
                cmp({tag, "_pulse"}, 32'(pulse), 32'(e.pulse));
                cmp({tag, "_credit_bcd"}, 32'(bcd), 32'(e.bcd));
                cmp({tag, "_credit_over"}, 32'(over), 32'(e.over));
            end
        end
        cmp({tag, "_bcd"}, 32'(bcd), 32'(toBcd(k)));
        cmp({tag, "_busy"}, 32'(busy), 32'(m_hold[k] > 0));
        cmp({tag, "_game_over"}, 32'(over), 32'(m_over[k]));
        if (m_over[k]) cmp({tag, "_winner"}, 32'(win), 32'(m_winner[k]));
    endtask

    // Monitor samples on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        checkOutput(0, pulse_a, bcd_a, over_a, winner_a, busy_a);
        checkOutput(1, pulse_b, {8'h00, bcd_b}, over_b, winner_b, busy_b);
    end

    task automatic applyStimulus(input logic [1:0] ev, input logic clr, input int n);
        score_event = ev;
        clear       = clr;
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [1:0] rnd_ev;

    initial begin
        pushed[0] = 0; pushed[1] = 0;
        seen[0]   = 0; seen[1]   = 0;
        reset       = 1'b1;
        clear       = 1'b0;
        score_event = 2'b00;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        $display("[TB] single point for player 0");
        applyStimulus(2'b01, 1'b0, 1);
        applyStimulus(2'b00, 1'b0, 8);
        cmp("a_p0_first_point", 32'(bcd_a), 32'h0001);

        $display("[TB] player 1 holds request for 100 cycles");
        applyStimulus(2'b10, 1'b0, 100);
        applyStimulus(2'b00, 1'b0, 8);
        cmp("a_p1_held_once", 32'(bcd_a[15:8]), 32'h01);

        $display("[TB] simultaneous rise on both players");
        applyStimulus(2'b11, 1'b0, 1);
        applyStimulus(2'b00, 1'b0, 8);
        cmp("a_tie_break", 32'(bcd_a), 32'h0102);

        $display("[TB] drive player 0 through carry, win and saturation");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(2'b01, 1'b0, 1);
            applyStimulus(2'b00, 1'b0, 6);
        end
        applyStimulus(2'b10, 1'b0, 1);
        applyStimulus(2'b00, 1'b0, 6);
        cmp("a_win_score", 32'(bcd_a[7:0]), 32'h11);
        cmp("a_over_after_win", 32'(over_a), 32'd1);
        cmp("a_winner_after_win", 32'(winner_a), 32'd0);
        cmp("b_saturated", 32'(bcd_b[3:0]), 32'h9);

        $display("[TB] clear together with a rise while game is over");
        applyStimulus(2'b01, 1'b1, 1);
        cmp("a_clear_bcd", 32'(bcd_a), 32'h0000);
        cmp("a_clear_over", 32'(over_a), 32'd0);
        cmp("a_clear_pulse", 32'(pulse_a), 32'd0);
        applyStimulus(2'b00, 1'b0, 4);

        $display("[TB] random phase");
        rnd_ev = 2'b00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) rnd_ev = 2'($urandom_range(0, 3));
            applyStimulus(rnd_ev, ($urandom_range(0, 39) == 0), 1);
        end

        $display("[TB] reset during lockout");
        applyStimulus(2'b00, 1'b1, 1);
        applyStimulus(2'b00, 1'b0, 2);
        applyStimulus(2'b01, 1'b0, 1);
        applyStimulus(2'b00, 1'b0, 1);
        cmp("a_busy_before_reset", 32'(busy_a), 32'd1);
        reset = 1'b1;
        #1;
        cmp("a_busy_in_reset", 32'(busy_a), 32'd0);
        cmp("a_bcd_in_reset", 32'(bcd_a), 32'h0000);
        @(posedge clk);
        #2;
        reset = 1'b0;
        applyStimulus(2'b00, 1'b0, 4);

        cmp("a_queue_drained", 32'(q_a.size()), 32'd0);
        cmp("b_queue_drained", 32'(q_b.size()), 32'd0);
        cmp("a_pulse_count", 32'(seen[0]), 32'(pushed[0]));
        cmp("b_pulse_count", 32'(seen[1]), 32'(pushed[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
